// File: rtl/dig_map_writer_if.sv
// -----------------------------------------------------------------------------
// dig_map_writer_if
// Groups the motion-side inputs and the map-side outputs of dig_map_writer.
//   frame_clk   vsync-rate strobe (rising edge starts a marking pass)
//   Player_X/Y  sprite top-left corner, pixels
//   dig_enable  sampled at the frame edge; 0 skips marking for that frame
//   Clear_map   level request to wipe the whole map
//   dug_state   tunnel bitmap, dug_state[col][row], 1 = dug
//   new_dig     one-cycle pulse for every tile that turned from 0 to 1
//   dug_count   number of dug tiles
//   busy        writer is marking or clearing
// master = the block driving requests (motion logic / bench),
// slave  = dig_map_writer itself.
// -----------------------------------------------------------------------------
interface dig_map_writer_if #(
  parameter int COLS = 32,
  parameter int ROWS = 24
);
  logic                       frame_clk;
  logic [9:0]                 Player_X;
  logic [9:0]                 Player_Y;
  logic                       dig_enable;
  logic                       Clear_map;
  logic [COLS-1:0][ROWS-1:0]  dug_state;
  logic                       new_dig;
  logic [9:0]                 dug_count;
  logic                       busy;

  modport master (
    output frame_clk, Player_X, Player_Y, dig_enable, Clear_map,
    input  dug_state, new_dig, dug_count, busy
  );

  modport slave (
    input  frame_clk, Player_X, Player_Y, dig_enable, Clear_map,
    output dug_state, new_dig, dug_count, busy
  );
endinterface

// File: rtl/dig_map_writer.sv
// -----------------------------------------------------------------------------
// dig_map_writer
// Owns the tile bitmap of dug tunnels. On each frame edge (when enabled) it
// marks the up-to-four tiles covered by the 16x16 player sprite, one tile per
// clock, counting and pulsing every newly dug tile. A Clear_map request wipes
// the map one column per clock.
// Ports:
//   Clk    system clock
//   Reset  asynchronous, active-low reset
//   bus    dig_map_writer_if.slave (frame strobe, sprite position, enables,
//          bitmap / count / pulse / busy outputs)
// The bitmap is stored column-major so that dug_state[col][row] addresses a
// tile directly and a whole column can be cleared in one cycle.
// -----------------------------------------------------------------------------
module dig_map_writer #(
  parameter int COLS     = 32,
  parameter int ROWS     = 24,
  parameter int FIELD_Y0 = 96,
  parameter int TILE     = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  dig_map_writer_if.slave bus
);
  localparam int TSH = $clog2(TILE);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);

  // 11-bit arithmetic so that coordinates up to 1023 + 15 never wrap
  localparam logic [10:0] X_END = 11'(COLS * TILE);
  localparam logic [10:0] Y_BEG = 11'(FIELD_Y0);
  localparam logic [10:0] Y_END = 11'(FIELD_Y0 + ROWS * TILE);
  localparam logic [10:0] EDGE  = 11'(TILE - 1);

  typedef enum logic [2:0] {IDLE, MARK0, MARK1, MARK2, MARK3, CLEAR} state_t;

  state_t                    state_q, state_d;
  logic                      frame_clk_q;
  logic [CW-1:0]             c0_q, c0_d, c1_q, c1_d;
  logic [RW-1:0]             r0_q, r0_d, r1_q, r1_d;
  logic                      c0v_q, c0v_d, c1v_q, c1v_d;
  logic                      r0v_q, r0v_d, r1v_q, r1v_d;
  logic [CW-1:0]             col_ptr_q, col_ptr_d;
  logic [COLS-1:0][ROWS-1:0] dug_q, dug_d;
  logic [9:0]                count_q, count_d;
  logic                      new_dig_q, new_dig_d;

  logic                      fe;
  logic [10:0]               x_lo, x_hi, y_lo, y_hi;
  logic                      use_c1, use_r1, cur_ok, cur_bit;
  logic [CW-1:0]             cur_col;
  logic [RW-1:0]             cur_row;

  assign fe   = bus.frame_clk & ~frame_clk_q;
  assign x_lo = {1'b0, bus.Player_X};
  assign x_hi = x_lo + EDGE;
  assign y_lo = {1'b0, bus.Player_Y};
  assign y_hi = y_lo + EDGE;

  // Tile visited in the current MARK state: MARK0 (c0,r0), MARK1 (c1,r0),
  // MARK2 (c0,r1), MARK3 (c1,r1).
  always_comb begin
    use_c1  = (state_q == MARK1) || (state_q == MARK3);
    use_r1  = (state_q == MARK2) || (state_q == MARK3);
    cur_col = use_c1 ? c1_q : c0_q;
    cur_row = use_r1 ? r1_q : r0_q;
    cur_ok  = (use_c1 ? c1v_q : c0v_q) && (use_r1 ? r1v_q : r0v_q);
    cur_bit = cur_ok ? dug_q[cur_col][cur_row] : 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    col_ptr_d = col_ptr_q;
    c0_d      = c0_q;
    c1_d      = c1_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    c0v_d     = c0v_q;
    c1v_d     = c1v_q;
    r0v_d     = r0v_q;
    r1v_d     = r1v_q;
    dug_d     = dug_q;
    count_d   = count_q;
    new_dig_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Clear_map) begin
          state_d   = CLEAR;
          col_ptr_d = '0;
        end else if (fe && bus.dig_enable) begin
          state_d = MARK0;
          c0_d    = CW'(x_lo >> TSH);
          c1_d    = CW'(x_hi >> TSH);
          // Below-field rows wrap here but are flagged invalid below.
          r0_d    = RW'((y_lo - Y_BEG) >> TSH);
          r1_d    = RW'((y_hi - Y_BEG) >> TSH);
          c0v_d   = (x_lo < X_END);
          c1v_d   = (x_hi < X_END);
          r0v_d   = (y_lo >= Y_BEG) && (y_lo < Y_END);
          r1v_d   = (y_hi >= Y_BEG) && (y_hi < Y_END);
        end
      end

      MARK0, MARK1, MARK2, MARK3: begin
        if (bus.Clear_map) begin
          // Abort: this cycle's tile is not written.
          state_d   = CLEAR;
          col_ptr_d = '0;
        end else begin
          // A tile already dug (including a duplicate corner) is skipped,
          // so every tile is counted exactly once.
          if (!cur_bit) begin
            dug_d[cur_col][cur_row] = 1'b1;
            new_dig_d               = 1'b1;
            count_d                 = count_q + 10'd1;
          end
          unique case (state_q)
            MARK0:   state_d = MARK1;
            MARK1:   state_d = MARK2;
            MARK2:   state_d = MARK3;
            default: state_d = IDLE;
          endcase
        end
      end

      CLEAR: begin
        dug_d[col_ptr_q] = '0;
        col_ptr_d        = col_ptr_q + 1'b1;
        if (col_ptr_q == CW'(COLS - 1)) begin
          count_d = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      frame_clk_q <= 1'b0;
      c0_q        <= '0;
      c1_q        <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      c0v_q       <= 1'b0;
      c1v_q       <= 1'b0;
      r0v_q       <= 1'b0;
      r1v_q       <= 1'b0;
      col_ptr_q   <= '0;
      dug_q       <= '0;
      count_q     <= '0;
      new_dig_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= bus.frame_clk;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      c0v_q       <= c0v_d;
      c1v_q       <= c1v_d;
      r0v_q       <= r0v_d;
      r1v_q       <= r1v_d;
      col_ptr_q   <= col_ptr_d;
      dug_q       <= dug_d;
      count_q     <= count_d;
      new_dig_q   <= new_dig_d;
    end
  end

  assign bus.dug_state = dug_q;
  assign bus.new_dig   = new_dig_q;
  assign bus.dug_count = count_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dig_map_writer.sv
// -----------------------------------------------------------------------------
// tb_dig_map_writer
// Directed bench for dig_map_writer: a table of frame vectors with
// hand-computed pulse/count expectations and a tile-level reference map,
// followed by hand-written sequences for clear, abort, dropped frame edges
// and asynchronous reset in the middle of marking/clearing.
// -----------------------------------------------------------------------------
module tb_dig_map_writer;
  logic clk;
  logic rst_n;

  dig_map_writer_if bus_if ();

  dig_map_writer dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0][23:0] model_map;

  typedef struct {
    bit pre_reset;
    int x;
    int y;
    bit en;
    int exp_pulses;
    int exp_count;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_map(input string name);
    int diff;
    diff = 0;
    checks++;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 24; r++)
        if (bus_if.dug_state[c][r] !== model_map[c][r]) diff++;
    if (diff != 0) begin
      errors++;
      $display("FAIL %s: %0d tiles differ from reference map (expected 0)", name, diff);
    end
  endtask

  // Reference: every corner pixel of the sprite that lies in the playfield
  // marks the tile containing it.
  task automatic model_mark(input int x, input int y, input bit en);
    int px, py;
    if (!en) return;
    for (int dx = 0; dx <= 15; dx += 15)
      for (int dy = 0; dy <= 15; dy += 15) begin
        px = x + dx;
        py = y + dy;
        if (px < 512 && py >= 96 && py < 480)
          model_map[px / 16][(py - 96) / 16] = 1'b1;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.frame_clk  = 1'b0;
    bus_if.Clear_map  = 1'b0;
    bus_if.dig_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_map = '0;
  endtask

  // One frame edge; counts new_dig pulses and busy cycles afterwards.
  task automatic do_frame(input int x, input int y, input bit en,
                          output int pulses, output int busy_n);
    @(negedge clk);
    bus_if.Player_X   = 10'(x);
    bus_if.Player_Y   = 10'(y);
    bus_if.dig_enable = en;
    bus_if.frame_clk  = 1'b1;
    @(negedge clk);
    bus_if.frame_clk  = 1'b0;
    pulses = 0;
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_if.busy === 1'b1) busy_n++;
      if (bus_if.new_dig === 1'b1) pulses++;
    end
    model_mark(x, y, en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p, b;

    vecs[0]  = '{1,   32,   96, 1, 1, 1};
    vecs[1]  = '{1,   40,  104, 1, 4, 4};
    vecs[2]  = '{0,   40,  104, 1, 0, 4};
    vecs[3]  = '{1,  504,  470, 1, 1, 1};
    vecs[4]  = '{0,    0,   80, 1, 0, 1};
    vecs[5]  = '{0,    0,   81, 1, 1, 2};
    vecs[6]  = '{0,    0,   60, 1, 0, 2};
    vecs[7]  = '{0,  200,  300, 0, 0, 2};
    vecs[8]  = '{0, 1016, 1016, 1, 0, 2};
    vecs[9]  = '{0,    0,  479, 1, 1, 3};
    vecs[10] = '{0,  511,   95, 1, 1, 4};
    vecs[11] = '{0,   16,  112, 1, 1, 5};
    vecs[12] = '{1,  496,  464, 1, 1, 1};

    rst_n = 1'b0;
    bus_if.frame_clk  = 1'b0;
    bus_if.Player_X   = '0;
    bus_if.Player_Y   = '0;
    bus_if.dig_enable = 1'b0;
    bus_if.Clear_map  = 1'b0;
    model_map = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset count", int'(bus_if.dug_count), 0);
    check("reset new_dig", int'(bus_if.new_dig), 0);
    check("reset busy", int'(bus_if.busy), 0);
    check_map("reset map");
    rst_n = 1'b1;
    $display("reset: count=%0d busy=%0d", bus_if.dug_count, bus_if.busy);

    // ---- table-driven frames ----
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre_reset) do_reset();
      do_frame(vecs[i].x, vecs[i].y, vecs[i].en, p, b);
      $display("vec %0d: x=%0d y=%0d en=%0d pulses=%0d busy=%0d count=%0d",
               i, vecs[i].x, vecs[i].y, vecs[i].en, p, b, bus_if.dug_count);
      check($sformatf("vec%0d pulses", i), p, vecs[i].exp_pulses);
      check($sformatf("vec%0d count", i), int'(bus_if.dug_count), vecs[i].exp_count);
      check($sformatf("vec%0d busy cycles", i), b, vecs[i].en ? 4 : 0);
      check_map($sformatf("vec%0d map", i));
    end

    // ---- dig 10 tiles, then a one-cycle clear request ----
    do_reset();
    for (int i = 0; i < 10; i++) do_frame(32 * i, 96, 1'b1, p, b);
    check("pre-clear count", int'(bus_if.dug_count), 10);
    check_map("pre-clear map");
    @(negedge clk);
    bus_if.Clear_map = 1'b1;
    @(negedge clk);
    bus_if.Clear_map = 1'b0;
    p = 0;
    b = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_if.busy === 1'b1) b++;
      if (bus_if.new_dig === 1'b1) p++;
    end
    model_map = '0;
    $display("clear: busy=%0d pulses=%0d count=%0d", b, p, bus_if.dug_count);
    check("clear busy cycles", b, 32);
    check("clear pulses", p, 0);
    check("clear count", int'(bus_if.dug_count), 0);
    check_map("clear map");

    // ---- Clear_map during MARK1 aborts the remaining tiles ----
    do_reset();
    @(negedge clk);
    bus_if.Player_X = 10'd40;
    bus_if.Player_Y = 10'd104;
    bus_if.dig_enable = 1'b1;
    bus_if.frame_clk = 1'b1;
    @(negedge clk);                 // MARK0
    bus_if.frame_clk = 1'b0;
    @(negedge clk);                 // MARK1, (2,0) already written
    p = (bus_if.new_dig === 1'b1) ? 1 : 0;
    bus_if.Clear_map = 1'b1;
    @(negedge clk);                 // CLEAR, MARK1 write suppressed
    bus_if.Clear_map = 1'b0;
    check("abort tile(2,0)", int'(bus_if.dug_state[2][0]), 1);
    check("abort tile(3,0)", int'(bus_if.dug_state[3][0]), 0);
    check("abort count", int'(bus_if.dug_count), 1);
    b = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_if.busy === 1'b1) b++;
      if (bus_if.new_dig === 1'b1) p++;
    end
    model_map = '0;
    $display("abort: pulses=%0d clear busy=%0d count=%0d", p, b, bus_if.dug_count);
    check("abort pulses", p, 1);
    check("abort clear busy", b, 32);
    check_map("abort map");

    // ---- frame edge while busy is dropped ----
    do_reset();
    @(negedge clk);
    bus_if.Player_X = 10'd40;
    bus_if.Player_Y = 10'd104;
    bus_if.dig_enable = 1'b1;
    bus_if.frame_clk = 1'b1;
    @(negedge clk);                 // MARK0
    bus_if.frame_clk = 1'b0;
    @(negedge clk);                 // MARK1: new edge with a different position
    bus_if.Player_X = 10'd200;
    bus_if.Player_Y = 10'd200;
    bus_if.frame_clk = 1'b1;
    @(negedge clk);
    bus_if.frame_clk = 1'b0;
    repeat (8) @(negedge clk);
    model_mark(40, 104, 1'b1);
    $display("busy-edge: count=%0d busy=%0d", bus_if.dug_count, bus_if.busy);
    check("busy-edge count", int'(bus_if.dug_count), 4);
    check("busy-edge idle", int'(bus_if.busy), 0);
    check_map("busy-edge map");

    // ---- async reset one cycle into CLEAR ----
    @(negedge clk);
    bus_if.Clear_map = 1'b1;
    @(negedge clk);
    bus_if.Clear_map = 1'b0;
    check("mid-clear busy", int'(bus_if.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    model_map = '0;
    $display("reset mid-clear: count=%0d busy=%0d", bus_if.dug_count, bus_if.busy);
    check("mid-clear reset count", int'(bus_if.dug_count), 0);
    check("mid-clear reset busy", int'(bus_if.busy), 0);
    check_map("mid-clear reset map");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- async reset in MARK2 ----
    @(negedge clk);
    bus_if.Player_X = 10'd40;
    bus_if.Player_Y = 10'd104;
    bus_if.dig_enable = 1'b1;
    bus_if.frame_clk = 1'b1;
    @(negedge clk);                 // MARK0
    bus_if.frame_clk = 1'b0;
    @(negedge clk);                 // MARK1
    @(negedge clk);                 // MARK2, pulse from (3,0)
    check("mark2 new_dig", int'(bus_if.new_dig), 1);
    check("mark2 count", int'(bus_if.dug_count), 2);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-mark: count=%0d new_dig=%0d busy=%0d",
             bus_if.dug_count, bus_if.new_dig, bus_if.busy);
    check("mid-mark reset new_dig", int'(bus_if.new_dig), 0);
    check("mid-mark reset busy", int'(bus_if.busy), 0);
    check("mid-mark reset count", int'(bus_if.dug_count), 0);
    check_map("mid-mark reset map");
    @(negedge clk);
    rst_n = 1'b1;

    // normal operation after the reset
    do_frame(32, 96, 1'b1, p, b);
    $display("post-reset frame: pulses=%0d count=%0d", p, bus_if.dug_count);
    check("post-reset pulses", p, 1);
    check("post-reset count", int'(bus_if.dug_count), 1);
    check_map("post-reset map");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
